// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 BCM streamer: FSM states, pixel
// layout, panel geometry and the gamma table used when HUB75_GAMMA_EN is set.
package hub75_pkg;

  localparam int COLS      = 64;
  localparam int ROWS_HALF = 8;
  localparam int BPC       = 8;
  localparam int ADDR_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY,
    BLANK
  } state_t;

  // Matches the framebuffer word layout {b, g, r}.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Gamma 2.0 curve: out = in*in/255, so 0 -> 0, 255 -> 255 and monotonic.
  function automatic logic [255:0][7:0] gamma_table();
    logic [255:0][7:0] t;
    for (int i = 0; i < 256; i++) begin
      t[i] = 8'((i * i) / 255);
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] GAMMA_LUT = gamma_table();

endpackage

// File: rtl/hub75_gamma.sv
// Per-channel gamma lookup: purely combinational read of the package table.
module hub75_gamma
  import hub75_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = GAMMA_LUT[din];

endmodule

// File: rtl/hub75_streamer.sv
// HUB75 1/8-scan BCM streamer: reads the framebuffer, shifts one bit plane per
// row, latches and displays it weighted by 2^bit. Define HUB75_GAMMA_EN for gamma.
module hub75_streamer
  import hub75_pkg::*;
#(
  parameter int COLS        = hub75_pkg::COLS,
  parameter int BASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              hub75_clk,
  output logic              hub75_lat,
  output logic              hub75_oe_,
  output logic [2:0]        hub75_row,
  output logic              hub75_r0,
  output logic              hub75_g0,
  output logic              hub75_b0,
  output logic              hub75_r1,
  output logic              hub75_g1,
  output logic              hub75_b1,
  output logic              frame_start
);

  localparam int COL_W  = $clog2(COLS);
  localparam int BIT_W  = $clog2(BPC);
  localparam int ROW_W  = $clog2(ROWS_HALF);
  localparam int DISP_W = $clog2(BASE_CYCLES) + BPC;

  state_t            state, state_d;
  logic [1:0]        phase, phase_d;
  logic [COL_W-1:0]  col, col_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DISP_W-1:0] disp_cnt, disp_d;
  logic [ADDR_W-1:0] rd_addr_d;
  rgb_t              upper_q, lower;
  logic [7:0]        up_r, up_g, up_b, lo_r, lo_g, lo_b;

  assign lower     = rgb_t'(rd_data);
  assign hub75_row = row_q;

`ifdef HUB75_GAMMA_EN
  hub75_gamma u_gamma_up_r (.din(upper_q.r), .dout(up_r));
  hub75_gamma u_gamma_up_g (.din(upper_q.g), .dout(up_g));
  hub75_gamma u_gamma_up_b (.din(upper_q.b), .dout(up_b));
  hub75_gamma u_gamma_lo_r (.din(lower.r),   .dout(lo_r));
  hub75_gamma u_gamma_lo_g (.din(lower.g),   .dout(lo_g));
  hub75_gamma u_gamma_lo_b (.din(lower.b),   .dout(lo_b));
`else
  assign up_r = upper_q.r;
  assign up_g = upper_q.g;
  assign up_b = upper_q.b;
  assign lo_r = lower.r;
  assign lo_g = lower.g;
  assign lo_b = lower.b;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state;
    phase_d = phase;
    col_d   = col;
    bit_d   = bit_q;
    row_d   = row_q;
    disp_d  = disp_cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          phase_d = '0;
          col_d   = '0;
        end
      end
      SHIFT: begin
        phase_d = phase + 2'd1;
        if (phase == 2'd3) begin
          if (col == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = LATCH;
          end else begin
            col_d = col + 1'b1;
          end
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        disp_d  = DISP_W'((BASE_CYCLES << bit_q) - 1);
      end
      DISPLAY: begin
        if (disp_cnt == '0) state_d = BLANK;
        else                disp_d  = disp_cnt - 1'b1;
      end
      BLANK: begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_W'(BPC - 1)) row_d = row_q + 1'b1;
        state_d = enable ? SHIFT : IDLE;
        phase_d = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Odd phases read the lower-half line, even phases the upper-half line.
  assign rd_addr_d = ADDR_W'((int'(row_d) + (phase_d[0] ? ROWS_HALF : 0)) * COLS
                             + int'(col_d));

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      col      <= '0;
      bit_q    <= '0;
      row_q    <= '0;
      disp_cnt <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      col      <= col_d;
      bit_q    <= bit_d;
      row_q    <= row_d;
      disp_cnt <= disp_d;
    end
  end

  // Control outputs are registered from next-state values so they line up
  // with the cycle the FSM is actually in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      hub75_clk   <= 1'b0;
      hub75_lat   <= 1'b0;
      hub75_oe_   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rd_en       <= (state_d == SHIFT) && !phase_d[1];
      if ((state_d == SHIFT) && !phase_d[1]) rd_addr <= rd_addr_d;
      hub75_clk   <= (state_d == SHIFT) && (phase_d == 2'd3);
      hub75_lat   <= (state_d == LATCH);
      hub75_oe_   <= (state_d != DISPLAY);
      frame_start <= (state_d == SHIFT) && (phase_d == 2'd0) && (col_d == '0)
                     && (row_d == '0) && (bit_d == '0);
    end
  end

  // Upper pixel arrives in c1; data lines load at the end of c2 (lower pixel
  // straight off rd_data) and are stable while hub75_clk is high in c3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upper_q  <= '0;
      hub75_r0 <= 1'b0;
      hub75_g0 <= 1'b0;
      hub75_b0 <= 1'b0;
      hub75_r1 <= 1'b0;
      hub75_g1 <= 1'b0;
      hub75_b1 <= 1'b0;
    end else if (state == SHIFT) begin
      if (phase == 2'd1) upper_q <= rgb_t'(rd_data);
      if (phase == 2'd2) begin
        hub75_r0 <= up_r[bit_q];
        hub75_g0 <= up_g[bit_q];
        hub75_b0 <= up_b[bit_q];
        hub75_r1 <= lo_r[bit_q];
        hub75_g1 <= lo_g[bit_q];
        hub75_b1 <= lo_b[bit_q];
      end
    end
  end

endmodule

// File: tb/tb_hub75_streamer.sv
// Directed bench for hub75_streamer: reset, addressing, BCM weights, row
// sequencing, enable drop/resume and mid-shift reset.
module tb_hub75_streamer;
  import hub75_pkg::*;

  localparam int NCOLS = 64;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data = '0;
  logic        hub75_clk, hub75_lat, hub75_oe_, frame_start;
  logic [2:0]  hub75_row;
  logic        hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1;
  logic [5:0]  data6;
  logic [23:0] px_up = 24'h000001;
  logic [23:0] px_lo = 24'h000001;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fs_times[$];

  hub75_streamer #(.COLS(NCOLS), .BASE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe_(hub75_oe_),
    .hub75_row(hub75_row),
    .hub75_r0(hub75_r0), .hub75_g0(hub75_g0), .hub75_b0(hub75_b0),
    .hub75_r1(hub75_r1), .hub75_g1(hub75_g1), .hub75_b1(hub75_b1),
    .frame_start(frame_start)
  );

  assign data6 = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1};

  always #5 clk = ~clk;

  // Framebuffer: one pixel value for the upper half, one for the lower half.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= (rd_addr < 10'd512) ? px_up : px_lo;
  end

  always @(negedge clk) if (frame_start) fs_times.push_back(cyc);

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_lines(input logic [23:0] up, input logic [23:0] lo,
                                           input int b);
    rgb_t u, l;
    u = rgb_t'(up);
    l = rgb_t'(lo);
`ifdef HUB75_GAMMA_EN
    u.r = GAMMA_LUT[u.r]; u.g = GAMMA_LUT[u.g]; u.b = GAMMA_LUT[u.b];
    l.r = GAMMA_LUT[l.r]; l.g = GAMMA_LUT[l.g]; l.b = GAMMA_LUT[l.b];
`endif
    return {u.r[b], u.g[b], u.b[b], l.r[b], l.g[b], l.b[b]};
  endfunction

  task automatic chk_reset(input string tag);
    check({tag, "_oe"}, hub75_oe_, 1);
    check({tag, "_outs"}, {hub75_clk, hub75_lat, hub75_row, data6, rd_en,
                           frame_start, rd_addr}, 0);
  endtask

  // Called at the negedge of the first SHIFT cycle; returns at the negedge
  // of the cycle after BLANK.
  task automatic plane(input int row, input int b, input int drop_at);
    int n = 0, clks = 0, oe_cnt = 0;
    int bad_data = 0, bad_addr = 0, bad_fs = 0, bad_ctl = 0;
    logic [9:0] ea;
    logic [5:0] ed;
    string t;
    t  = $sformatf("r%0d_p%0d", row, b);
    ed = exp_lines(px_up, px_lo, b);
    while (!hub75_lat && n < 4 * NCOLS + 8) begin
      if (n % 4 < 2) begin
        ea = 10'(((n % 4 == 1) ? row + 8 : row) * NCOLS + n / 4);
        if (!rd_en || rd_addr != ea) bad_addr++;
      end else if (rd_en) begin
        bad_addr++;
      end
      if (hub75_clk) begin
        clks++;
        if (data6 != ed) bad_data++;
      end
      if (frame_start != (row == 0 && b == 0 && n == 0)) bad_fs++;
      if (!hub75_oe_ || hub75_row != 3'(row)) bad_ctl++;
      @(negedge clk);
      n++;
    end
    check({t, "_shift_len"}, n, 4 * NCOLS);
    check({t, "_clk_edges"}, clks, NCOLS);
    check({t, "_data"}, bad_data, 0);
    check({t, "_addr"}, bad_addr, 0);
    check({t, "_frame_start"}, bad_fs, 0);
    check({t, "_oe_row"}, bad_ctl, 0);
    check({t, "_latch"}, {hub75_lat, hub75_clk, hub75_oe_}, 3'b101);
    @(negedge clk);
    while (!hub75_oe_ && oe_cnt < 1000) begin
      oe_cnt++;
      if (oe_cnt == drop_at) enable = 1'b0;
      @(negedge clk);
    end
    check({t, "_oe_low"}, oe_cnt, 4 << b);
    @(negedge clk);
  endtask

  initial begin
    int idle_act;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset_held");

    reset = 1'b0;
    idle_act = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_en || hub75_clk || !hub75_oe_) idle_act++;
    end
    check("idle_after_reset", idle_act, 0);

    // Full frame of 0x000001: only plane 0 carries data.
    enable = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 8; b++) plane(r, b, -1);

    for (int b = 0; b < 5; b++) plane(0, b, -1);
    check("frame_period", (fs_times.size() >= 2) ? fs_times[1] - fs_times[0] : -1, 24672);

    // Drop enable mid-display of plane 5, then idle without shifting.
    plane(0, 5, 60);
    idle_act = 0;
    repeat (40) begin
      if (rd_en || hub75_clk || !hub75_oe_ || hub75_lat) idle_act++;
      @(negedge clk);
    end
    check("idle_after_drop", idle_act, 0);

    px_up  = 24'h000040;
    px_lo  = 24'h000040;
    enable = 1'b1;
    @(negedge clk);
    plane(0, 6, -1);
    plane(0, 7, -1);

    // Reset in the middle of row 1, plane 0, column 30.
    px_up = 24'hFF00FF;
    px_lo = 24'h0000FF;
    repeat (121) @(negedge clk);
    check("pre_reset_row", hub75_row, 1);
    check("pre_reset_data", data6, 6'b101100);
    reset = 1'b1;
    #1;
    chk_reset("reset_async");
    @(negedge clk);
    chk_reset("reset_hold");

    px_lo = 24'h000000;
    reset = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 8; b++) plane(0, b, -1);
    px_up = 24'h000000;
    plane(1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_streamer.md
# hub75_streamer

Drives a 1/8-scan HUB75 panel with upper and lower halves, 64 columns and 16 rows, from a 24-bit RGB framebuffer using binary code modulation (BCM). It sits between the framebuffer RAM read port and the panel pins in CubeTop. It produces hub75_clk, hub75_lat, hub75_oe_, hub75_row and the six colour data lines. Rows are scanned 0..7. Each row gets 8 bit planes, from LSB to MSB, and each plane's display time is weighted by 2^bit.

## Interface
- COLS, 64, columns per row (shift clocks per plane)
- BASE_CYCLES, 4, oe_-low cycles for bit plane 0; plane b displays BASE_CYCLES<<b cycles
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; sampled only at plane boundaries
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  10  pixel address = row_line*COLS + col
- rd_data  in  24  {b[7:0], g[7:0], r[7:0]}, valid 1 cycle after rd_en
- hub75_clk  out  1  panel shift clock; panel samples data on the rising edge
- hub75_lat  out  1  latch pulse
- hub75_oe_  out  1  output enable, active-low
- hub75_row  out  3  row select
- hub75_r0, hub75_g0, hub75_b0  out  1 each  upper-half data (rows 0..7)
- hub75_r1, hub75_g1, hub75_b1  out  1 each  lower-half data (rows 8..15)
- frame_start  out  1  single-cycle pulse when row 0 / plane 0 shifting begins

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY, BLANK.
- Reset values: hub75_oe_=1. Every other output is 0, including hub75_row, bit counter and column counter.
- IDLE -> SHIFT when enable=1.
- SHIFT: each column takes 4 cycles, with col running from 0 to COLS-1.
  - c0: rd_addr = row*COLS+col, rd_en=1.
  - c1: rd_addr = (row+8)*COLS+col, rd_en=1. Capture the upper pixel.
  - c2: capture the lower pixel. Drive the six data lines with bit `bit` of each channel. hub75_clk=0.
  - c3: hub75_clk=1.
- SHIFT lasts 4*COLS cycles. hub75_oe_ stays 1 throughout.
- LATCH: one cycle with hub75_lat=1 and hub75_clk=0.
- DISPLAY: hub75_oe_=0 for exactly BASE_CYCLES<<bit cycles.
- BLANK: one cycle with hub75_oe_=1. In this cycle:
  - bit increments.
  - On bit wrap 7->0, hub75_row increments, wrapping 7->0.
  - Next state is SHIFT if enable=1, otherwise IDLE.
- hub75_row changes only in BLANK, never while oe_=0.
- frame_start pulses in the first SHIFT cycle when row=0 and bit=0.
- enable dropping mid-plane has no effect until BLANK. The current plane always completes shift, latch and display.
- Re-enable from IDLE resumes at the stored row/bit. Nothing is skipped.
- Data lines hold their last value outside SHIFT.

## Timing
- All outputs are registered. No combinational path from input to output.
- Read latency is fixed at 1 cycle. There is no backpressure; the framebuffer must return data every cycle.
- Per-plane period = 4*COLS + 1 + (BASE_CYCLES<<bit) + 1 cycles.
- With defaults, the row period is 8*258 + 4*255 = 3084 cycles. The frame period is 24672 cycles.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The state machine returns to IDLE, and row and bit clear.
- Width rules:
  - Display counter is at least log2(BASE_CYCLES)+8 bits.
  - Address arithmetic is 10 bits, unsigned.

## Configuration
- HUB75_GAMMA_EN defined: each 8-bit channel of rd_data passes through a 256-entry gamma LUT before bit selection. The LUT is combinational on the captured data, so latency is unchanged.
  - LUT[0]=0 and LUT[255]=255, monotonic.
- HUB75_GAMMA_EN undefined: raw channel bits are used, and no LUT is instantiated.

## Structure
- Package hub75_pkg holds:
  - the state enum;
  - the COLS, ROWS_HALF=8 and BPC=8 constants;
  - the gamma table constant.
- Sub-module hub75_gamma is the per-channel LUT, instantiated 6 times and only under HUB75_GAMMA_EN.
- All sequencing stays in hub75_streamer.

## Test plan
- Reset with enable=0 -> oe_=1, clk/lat/row/data/rd_en=0 and held. Release with enable=1 -> frame_start pulses in the first SHIFT cycle and rd_addr sequence is 0,512,1,513,…,63,575.
- Framebuffer all 0x000001, enable=1 -> in plane 0, r0=r1=1 on all 64 hub75_clk rising edges; planes 1..7 shift all zeros. oe_ low is 4 cycles after plane 0 and 512 cycles after plane 7.
- Row sequencing -> row 3 SHIFT begins rd_addr 192,704. After row 7 plane 7 BLANK, row=0 and frame_start repeats 24672 cycles after the first.
- Deassert enable midway through a plane-5 DISPLAY -> oe_ stays low the full 128 cycles, then BLANK, then IDLE with no hub75_clk edges. Re-assert enable -> the next shift is plane 6 of the same row.
- Assert reset during SHIFT at column 30 -> outputs return to reset values immediately. After release, the first read is rd_addr 0 with frame_start.
- HUB75_GAMMA_EN defined, pixel 0xFF00FF -> r and b are 1 in all 8 planes and g is 0. Pixel 0x000000 -> all lines are 0.
